// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM encoding,
// payload limits and the header byte layout.
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_PARITY  = 3'd4
    } tx_state_e;

    localparam int MAX_PAYLOAD = 63;
    localparam int BUF_DEPTH   = MAX_PAYLOAD + 1;

    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] hdr;
        hdr = 8'h00;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Host-side request/load signals and router-side byte stream of the packet
// transmitter; master is the transmitter, slave is the host/router side.
interface router_pkt_tx_if;

    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] payload_len;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_active;
    logic       tx_done;
    logic       req_err;

    modport master (
        input  start, dest_addr, payload_len, src_data, src_valid, busy,
        output src_ready, pkt_valid, data_out, tx_active, tx_done, req_err
    );

    modport slave (
        output start, dest_addr, payload_len, src_data, src_valid, busy,
        input  src_ready, pkt_valid, data_out, tx_active, tx_done, req_err
    );

endinterface

// File: rtl/router_tx_buf.sv
// Payload byte store: one synchronous write port, one combinational read port.
// Contents are never reset; a location is only read after it was written.
module router_tx_buf
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       we,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [BUF_DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a host payload, then streams
// header, payload and an XOR parity byte to the router under busy back-pressure.
module router_pkt_tx
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    router_pkt_tx_if.master   bus
);

    tx_state_e  state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [5:0] len_q, len_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] parity_q, parity_d;
    logic [7:0] data_q, data_d;
    logic       pv_q, pv_d;
    logic       active_q;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       buf_we;
    logic [7:0] buf_rd_data;

    // The one counter serves as write index while loading and read index while sending.
    router_tx_buf u_buf (
        .clock   (clock),
        .we      (buf_we),
        .wr_addr (cnt_q),
        .wr_data (bus.src_data),
        .rd_addr (cnt_q),
        .rd_data (buf_rd_data)
    );

    assign bus.src_ready = (state_q == ST_LOAD);
    assign bus.pkt_valid = pv_q;
    assign bus.data_out  = data_q;
    assign bus.tx_active = active_q;
    assign bus.tx_done   = done_q;
    assign bus.req_err   = err_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        data_d   = data_q;
        pv_d     = pv_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        buf_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_d = 8'h00;
                pv_d   = 1'b0;
                if (bus.start) begin
                    if (bus.payload_len == 6'd0 || bus.dest_addr == ADDR_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d   = bus.dest_addr;
                        len_d    = bus.payload_len;
                        parity_d = make_header(bus.payload_len, bus.dest_addr);
                        cnt_d    = 6'd0;
                        state_d  = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (bus.src_valid) begin
                    buf_we   = 1'b1;
                    parity_d = parity_q ^ bus.src_data;
                    if (cnt_q == len_q - 6'd1) begin
                        // Header goes out on the same edge the last byte lands.
                        state_d = ST_HEADER;
                        data_d  = make_header(len_q, addr_q);
                        pv_d    = 1'b1;
                        cnt_d   = 6'd0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end

            ST_HEADER: begin
                if (!bus.busy) begin
                    state_d = ST_PAYLOAD;
                    data_d  = buf_rd_data;
                    cnt_d   = cnt_q + 6'd1;
                end
            end

            ST_PAYLOAD: begin
                if (!bus.busy) begin
                    if (cnt_q == len_q) begin
                        state_d = ST_PARITY;
                        pv_d    = 1'b0;
                        data_d  = parity_q;
                    end else begin
                        data_d = buf_rd_data;
                        cnt_d  = cnt_q + 6'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (!bus.busy) begin
                    state_d = ST_IDLE;
                    data_d  = 8'h00;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                data_d  = 8'h00;
                pv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= 2'd0;
            len_q    <= 6'd0;
            cnt_q    <= 6'd0;
            parity_q <= 8'h00;
            data_q   <= 8'h00;
            pv_q     <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            data_q   <= data_d;
            pv_q     <= pv_d;
            active_q <= (state_d != ST_IDLE);
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus queues expected packet bytes,
// a negedge monitor compares every presented byte and the status pulses.
module tb_router_pkt_tx;

    logic clock;
    logic reset;

    router_pkt_tx_if bus ();

    router_pkt_tx dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       pv;
    } exp_t;

    exp_t       sb[$];
    int         len_q[$];
    int         err_q[$];
    logic [7:0] pay[$];

    int cyc           = 0;
    int errors        = 0;
    int checks        = 0;
    int done_cnt      = 0;
    int stim_timeouts = 0;
    int pkts_expected = 0;
    int busy_mode     = 0;
    int a5_cnt        = 0;
    bit finishing     = 1'b0;

    bit in_pkt      = 1'b0;
    bit expect_done = 1'b0;
    bit chk_idle    = 1'b0;
    int hdr_cyc     = 0;
    int stalls      = 0;
    int cur_len     = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Back-pressure driver: off, random, or three stall cycles on byte A5.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (busy_mode)
                1: bus.busy = ($urandom_range(0, 2) == 0);
                2: begin
                    if (bus.pkt_valid && bus.data_out == 8'hA5 && a5_cnt < 3) begin
                        bus.busy = 1'b1;
                        a5_cnt++;
                    end else begin
                        bus.busy = 1'b0;
                    end
                end
                default: bus.busy = 1'b0;
            endcase
            if (busy_mode != 2) a5_cnt = 0;
        end
    end

    // Monitor: outputs are stable at negedge; busy seen here is what the next edge uses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (finishing) begin
                chk("sb_empty", sb.size(), 0);
                chk("req_err_pending", err_q.size(), 0);
                chk("stim_timeouts", stim_timeouts, 0);
                chk("packets_done", done_cnt, pkts_expected);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end else if (reset) begin
                sb.delete();
                len_q.delete();
                in_pkt      = 1'b0;
                expect_done = 1'b0;
                chk_idle    = 1'b1;
            end else begin
                if (chk_idle) begin
                    chk("idle_pkt_valid", bus.pkt_valid, 0);
                    chk("idle_data_out", bus.data_out, 0);
                    chk("idle_tx_active", bus.tx_active, 0);
                    chk("idle_src_ready", bus.src_ready, 0);
                    chk_idle = 1'b0;
                end

                if (err_q.size() > 0 && err_q[0] == cyc) begin
                    void'(err_q.pop_front());
                    chk("req_err_pulse", bus.req_err, 1);
                    chk("req_err_src_ready", bus.src_ready, 0);
                    chk("req_err_pkt_valid", bus.pkt_valid, 0);
                    chk("req_err_tx_active", bus.tx_active, 0);
                end else begin
                    chk("req_err_quiet", bus.req_err, 0);
                end

                if (expect_done) begin
                    chk("tx_done_pulse", bus.tx_done, 1);
                    chk("done_data_out", bus.data_out, 0);
                    chk("done_pkt_valid", bus.pkt_valid, 0);
                    chk("done_tx_active", bus.tx_active, 0);
                    chk("tx_cycles", cyc - hdr_cyc, cur_len + 2 + stalls);
                    done_cnt++;
                    expect_done = 1'b0;
                end else begin
                    chk("tx_done_quiet", bus.tx_done, 0);
                end

                if (!in_pkt && bus.pkt_valid) begin
                    if (sb.size() == 0 || len_q.size() == 0) begin
                        chk("pkt_unexpected", bus.pkt_valid, 0);
                    end else begin
                        in_pkt  = 1'b1;
                        hdr_cyc = cyc;
                        stalls  = 0;
                        cur_len = len_q.pop_front();
                    end
                end

                if (in_pkt) begin
                    if (sb.size() == 0) begin
                        chk("pkt_overrun", bus.pkt_valid, 0);
                        in_pkt = 1'b0;
                    end else begin
                        e = sb[0];
                        chk("pkt_byte", bus.data_out, e.data);
                        chk("pkt_valid", bus.pkt_valid, e.pv);
                        chk("pkt_tx_active", bus.tx_active, 1);
                        if (bus.busy) begin
                            stalls++;
                        end else begin
                            void'(sb.pop_front());
                            if (!e.pv) begin
                                in_pkt      = 1'b0;
                                expect_done = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference model: header is len*4+addr, parity is XOR of header and all payload.
    task automatic load_pkt(input logic [1:0] a, input logic [5:0] l, input bit gaps, input bit noise);
        logic [7:0] par;
        exp_t       e;
        bit         ok;
        par = 8'(int'(l) * 4 + int'(a));
        e.data = par;
        e.pv   = 1'b1;
        sb.push_back(e);
        for (int i = 0; i < int'(l); i++) begin
            par    = par ^ pay[i];
            e.data = pay[i];
            e.pv   = 1'b1;
            sb.push_back(e);
        end
        e.data = par;
        e.pv   = 1'b0;
        sb.push_back(e);
        len_q.push_back(int'(l));

        @(posedge clock);
        #1;
        bus.start       = 1'b1;
        bus.dest_addr   = a;
        bus.payload_len = l;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        for (int i = 0; i < int'(l); i++) begin
            if (gaps) begin
                bus.src_valid = 1'b0;
                @(posedge clock);
                #1;
            end
            if (noise && i == 0) begin
                bus.start       = 1'b1;
                bus.dest_addr   = 2'($urandom_range(0, 2));
                bus.payload_len = 6'($urandom_range(1, 63));
            end
            bus.src_valid = 1'b1;
            bus.src_data  = pay[i];
            ok = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clock);
                if (bus.src_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                stim_timeouts++;
                $display("FAIL src_ready_timeout: byte %0d never accepted", i);
            end
            @(posedge clock);
            #1;
            bus.src_valid = 1'b0;
            bus.start     = 1'b0;
        end
        if (noise) begin
            @(posedge clock);
            #1;
            @(posedge clock);
            #1;
            bus.start       = 1'b1;
            bus.dest_addr   = 2'd1;
            bus.payload_len = 6'd2;
            @(posedge clock);
            #1;
            bus.start = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 3000 && done_cnt < pkts_expected; k++) @(negedge clock);
        if (done_cnt < pkts_expected) begin
            stim_timeouts++;
            $display("FAIL pkt_done_timeout: done=%0d required=%0d", done_cnt, pkts_expected);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input bit gaps, input bit noise);
        pkts_expected++;
        load_pkt(a, l, gaps, noise);
        wait_done();
    endtask

    task automatic bad_start(input logic [1:0] a, input logic [5:0] l);
        @(posedge clock);
        #1;
        err_q.push_back(cyc + 1);
        bus.start       = 1'b1;
        bus.dest_addr   = a;
        bus.payload_len = l;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        bit found;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.dest_addr   = 2'd0;
        bus.payload_len = 6'd0;
        bus.src_data    = 8'h00;
        bus.src_valid   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reference packet: 09 A5 3C 90.
        pay.delete();
        pay.push_back(8'hA5);
        pay.push_back(8'h3C);
        run_pkt(2'd1, 6'd2, 1'b0, 1'b0);

        busy_mode = 2;
        run_pkt(2'd1, 6'd2, 1'b0, 1'b0);
        busy_mode = 0;

        bad_start(2'd3, 6'd5);
        bad_start(2'd1, 6'd0);
        bad_start(2'd3, 6'd0);

        fill_random(63);
        run_pkt(2'd2, 6'd63, 1'b1, 1'b0);

        fill_random(5);
        run_pkt(2'd0, 6'd5, 1'b0, 1'b1);

        // Abort mid-payload with a concurrent start that reset must override.
        fill_random(5);
        pay[0] = 8'h11;
        load_pkt(2'd2, 6'd5, 1'b0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (bus.pkt_valid && bus.data_out == 8'h11) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            stim_timeouts++;
            $display("FAIL reset_test_timeout: first payload byte never presented");
        end
        @(posedge clock);
        #1;
        reset           = 1'b1;
        bus.start       = 1'b1;
        bus.dest_addr   = 2'd1;
        bus.payload_len = 6'd3;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        fill_random(4);
        run_pkt(2'd1, 6'd4, 1'b0, 1'b0);

        busy_mode = 1;
        for (int i = 0; i < 14; i++) begin
            logic [5:0] l;
            logic [1:0] a;
            l = (i % 5 == 0) ? 6'd63 : ((i % 5 == 1) ? 6'd1 : 6'($urandom_range(1, 16)));
            a = 2'($urandom_range(0, 2));
            fill_random(int'(l));
            run_pkt(a, l, 1'($urandom_range(0, 1)), (l >= 6'd4) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (i % 3 == 0) begin
                if ($urandom_range(0, 1) == 1) bad_start(2'd3, 6'($urandom_range(0, 63)));
                else bad_start(2'($urandom_range(0, 2)), 6'd0);
            end
        end
        busy_mode = 0;

        repeat (10) @(posedge clock);
        #1;
        finishing = 1'b1;
    end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 Parameter: none; all widths fixed by the router packet format.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request to send one packet; sampled only in IDLE.
REQ-005 dest_addr  in  2  destination port 0..2; 3 is illegal.
REQ-006 payload_len  in  6  payload byte count 1..63; 0 is illegal.
REQ-007 src_data  in  8  payload byte from host.
REQ-008 src_valid  in  1  src_data valid.
REQ-009 src_ready  out  1  tx accepts src_data; a byte transfers on an edge with src_valid && src_ready.
REQ-010 busy  in  1  router back-pressure; byte on data_out is consumed only on an edge with busy==0.
REQ-011 pkt_valid  out  1  high for header and payload bytes, low for the parity byte.
REQ-012 data_out  out  8  packet byte to router input.
REQ-013 tx_active  out  1  high in every state except IDLE.
REQ-014 tx_done  out  1  one-cycle pulse after parity byte consumed.
REQ-015 req_err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, HEADER, PAYLOAD, PARITY; all outputs registered except src_ready.
REQ-017 In IDLE, start with payload_len==0 or dest_addr==3 SHALL pulse req_err next cycle and remain IDLE.
REQ-018 In IDLE, legal start SHALL latch dest_addr, payload_len, set parity accumulator to header {payload_len, dest_addr}, clear load count, go to LOAD.
REQ-019 src_ready SHALL equal (state==LOAD); each transferred byte is written to the payload buffer at load count, XORed into parity, count incremented.
REQ-020 On the edge transferring byte number payload_len, FSM SHALL enter HEADER with data_out=header, pkt_valid=1 at that edge.
REQ-021 Once pkt_valid rises, no bubble SHALL occur: every consumed byte is replaced at the same edge by the next byte.
REQ-022 While busy==1, data_out and pkt_valid SHALL hold unchanged.
REQ-023 HEADER consumed -> PAYLOAD presenting buffer[0]; payload byte k consumed -> buffer[k+1]; last payload consumed -> PARITY with pkt_valid=0, data_out=parity.
REQ-024 PARITY consumed -> IDLE, tx_done=1 for one cycle, data_out=8'h00.
REQ-025 With busy held low, transmission SHALL take exactly payload_len+2 cycles from header to IDLE.
REQ-026 start asserted outside IDLE SHALL be ignored, not queued.
REQ-027 In IDLE, pkt_valid=0, data_out=8'h00.
REQ-028 Counters SHALL be 6-bit; no wrap, since payload_len<=63.

Reset
REQ-029 reset SHALL force IDLE, pkt_valid=0, data_out=8'h00, tx_done=0, req_err=0, counters and parity 0, in any state including mid-packet.
REQ-030 Payload buffer contents SHALL NOT be reset; they are don't-care until written.
REQ-031 reset SHALL take priority over start, busy and src_valid in the same cycle.

Structure
REQ-032 Shared package router_pkg SHALL hold FSM state encoding, MAX_PAYLOAD=63, ADDR_ILLEGAL=2'b11, header field positions (len [7:2], addr [1:0]).
REQ-033 Payload storage SHALL be sub-module router_tx_buf: 64x8 register array, one sync write port, one combinational read port.

Verification
REQ-034 addr=1, len=2, payload A5,3C, busy=0 -> data_out 09(pv=1), A5, 3C(pv=1), 90(pv=0), then tx_done pulse; 4 cycles.
REQ-035 Same packet, busy=1 for 3 cycles during byte A5 -> A5 held 4 cycles, order and parity 90 unchanged.
REQ-036 start with addr=3, or len=0 -> req_err pulse, src_ready stays 0, no pkt_valid.
REQ-037 len=63, src_valid toggled every other cycle -> 63 bytes loaded, header FC|addr, 65-cycle gap-free transmit, correct parity.
REQ-038 reset asserted during PAYLOAD -> next cycle IDLE, pkt_valid=0, data_out=00; following legal start sends a clean packet.
REQ-039 start pulsed during LOAD and PAYLOAD -> ignored; exactly one packet transmitted.
